// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised input, mid-bit sampling, one-cycle
// valid / frame_err strobes aligned one cycle after the stop-bit sample pulse.
module uart_rx #(
    parameter logic [12:0] T_DIV      = 13'd5207,
    parameter logic [12:0] T_DIV_HALF = 13'd2603
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       uart_rxd,
    output logic [7:0] dout,
    output logic       valid,
    output logic       frame_err,
    output logic       clk_rx_en,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t      state_q, state_d;
    logic        sync1_q, rxd_s_q;
    logic [12:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dout_q;
    logic        clk_rx_en_q, ok_q, err_q, valid_q, frame_err_q;
    logic        sample_pt, stop_ok, stop_bad;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            clk_rx_en_q <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= uart_rxd;
            rxd_s_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            clk_rx_en_q <= sample_pt;
            // Stop-bit verdict is delayed one extra stage so the strobe lands
            // in the cycle after the clk_rx_en pulse of the stop sample.
            ok_q        <= stop_ok;
            err_q       <= stop_bad;
            valid_q     <= ok_q;
            frame_err_q <= err_q;
            if (ok_q) begin
                dout_q <= shift_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (!rxd_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == T_DIV_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxd_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            DATA: begin
                if (cnt_q == T_DIV) begin
                    shift_d[idx_q] = rxd_s_q;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            STOP: begin
                if (cnt_q == T_DIV) begin
                    cnt_d   = '0;
                    state_d = rxd_s_q ? IDLE : BRK;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            BRK: begin
                // A line held low after a bad stop bit must not start a frame.
                if (rxd_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sample_pt = ((state_q == START) && (cnt_q == T_DIV_HALF)) ||
                    (((state_q == DATA) || (state_q == STOP)) && (cnt_q == T_DIV));
        stop_ok   = (state_q == STOP) && (cnt_q == T_DIV) && rxd_s_q;
        stop_bad  = (state_q == STOP) && (cnt_q == T_DIV) && !rxd_s_q;
        busy      = (state_q != IDLE);
    end

    assign dout      = dout_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign clk_rx_en = clk_rx_en_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bit-banged and random frames checked against a
// timing/content model derived from the frame rules.
module tb_uart_rx;
    localparam logic [12:0] TD = 13'd7;
    localparam logic [12:0] TH = 13'd3;
    localparam int TDI = 7;
    localparam int THI = 3;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       uart_rxd;
    logic [7:0] dout;
    logic       valid, frame_err, clk_rx_en, busy;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int both_cnt = 0;

    int obs_en[$], obs_vc[$], obs_vb[$], obs_f[$];
    int exp_en[$], exp_vc[$], exp_vb[$], exp_f[$];
    int en_rd = 0, v_rd = 0, f_rd = 0;

    uart_rx #(.T_DIV(TD), .T_DIV_HALF(TH)) dut (
        .clk(clk), .n_rst(n_rst), .uart_rxd(uart_rxd), .dout(dout),
        .valid(valid), .frame_err(frame_err), .clk_rx_en(clk_rx_en), .busy(busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (n_rst) begin
            if (clk_rx_en) obs_en.push_back(cyc);
            if (valid) begin
                obs_vc.push_back(cyc);
                obs_vb.push_back(int'(dout));
            end
            if (frame_err) obs_f.push_back(cyc);
            if (valid && frame_err) both_cnt <= both_cnt + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_rxd = v;
        repeat (TDI + 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Expected events follow from the frame rules: the first sync edge n,
    // then sample k at n+3+TH+k*(TD+1), and the strobe one cycle later.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        int n;
        n = cyc + 1;
        for (int k = 0; k < 10; k++) exp_en.push_back(n + 3 + THI + k * (TDI + 1));
        if (stop) begin
            exp_vc.push_back(n + 4 + THI + 9 * (TDI + 1));
            exp_vb.push_back(int'(b));
        end else begin
            exp_f.push_back(n + 4 + THI + 9 * (TDI + 1));
        end
        drive_bit(1'b0);
        for (int k = 0; k < 8; k++) drive_bit(b[k]);
        drive_bit(stop);
    endtask

    task automatic sync_check(input string tag);
        chk({tag, "_en_count"}, obs_en.size() - en_rd, exp_en.size());
        for (int i = 0; i < exp_en.size(); i++)
            if (en_rd + i < obs_en.size()) chk({tag, "_en_cycle"}, obs_en[en_rd + i], exp_en[i]);
        chk({tag, "_valid_count"}, obs_vc.size() - v_rd, exp_vc.size());
        for (int i = 0; i < exp_vc.size(); i++)
            if (v_rd + i < obs_vc.size()) begin
                chk({tag, "_valid_cycle"}, obs_vc[v_rd + i], exp_vc[i]);
                chk({tag, "_dout"}, obs_vb[v_rd + i], exp_vb[i]);
            end
        chk({tag, "_ferr_count"}, obs_f.size() - f_rd, exp_f.size());
        for (int i = 0; i < exp_f.size(); i++)
            if (f_rd + i < obs_f.size()) chk({tag, "_ferr_cycle"}, obs_f[f_rd + i], exp_f[i]);
        en_rd = obs_en.size();
        v_rd  = obs_vc.size();
        f_rd  = obs_f.size();
        exp_en.delete();
        exp_vc.delete();
        exp_vb.delete();
        exp_f.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(tag, int'(busy), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, int'({dout, valid, frame_err, clk_rx_en, busy}), 0);
    endtask

    initial begin
        logic [7:0] rb, last;
        n_rst    = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_state");
        n_rst = 1'b1;
        idle(10);
        chk_reset_outputs("post_reset_idle");

        send_frame(8'h37, 1'b1);
        idle(12);
        sync_check("frame37");

        send_frame(8'h20, 1'b1);
        idle(10);
        chk("busy_between", int'(busy), 0);
        send_frame(8'h00, 1'b1);
        idle(12);
        sync_check("frames20_00");

        begin
            int n;
            n = cyc + 1;
            exp_en.push_back(n + 3 + THI);
            uart_rxd = 1'b0;
            repeat (2) @(negedge clk);
            uart_rxd = 1'b1;
            wait_idle("glitch_idle", 8);
            idle(12);
            sync_check("glitch");
        end

        send_frame(8'h5A, 1'b1);
        idle(12);
        sync_check("pre_ferr");
        send_frame(8'hA5, 1'b0);
        uart_rxd = 1'b0;
        repeat (40) @(negedge clk);
        chk("break_busy", int'(busy), 1);
        chk("break_dout_kept", int'(dout), 8'h5A);
        uart_rxd = 1'b1;
        wait_idle("break_release", 6);
        idle(12);
        sync_check("ferr");

        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        idle(12);
        sync_check("b2b");

        uart_rxd = 1'b0;
        repeat (TDI + 1) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (4 * (TDI + 1) + 4) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_reset_0");
        @(negedge clk);
        chk_reset_outputs("mid_reset_1");
        n_rst = 1'b1;
        idle(100);
        chk("abort_no_valid", obs_vc.size() - v_rd, 0);
        chk("abort_no_ferr", obs_f.size() - f_rd, 0);
        en_rd = obs_en.size();
        send_frame(8'h3C, 1'b1);
        idle(12);
        sync_check("after_reset");
        chk("dout_3c", int'(dout), 8'h3C);

        last = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom);
            last = rb;
            send_frame(rb, 1'b1);
            idle($urandom_range(0, 12));
        end
        idle(12);
        sync_check("random");
        chk("random_last_dout", int'(dout), int'(last));
        chk("never_both", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
